// File: rtl/tl_ram_slave_pkg.sv
// Shared TileLink-UL definitions for the RAM responder: opcodes, D-beat payload and decode helpers.
package tl_pkg;

    localparam int unsigned TL_DATA_W = 64;
    localparam int unsigned TL_SRC_W  = 4;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_DATA_W-1:0] data;
        logic                 error;
    } tl_d_beat_t;

    function automatic logic a_op_supported(input logic [2:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) || (op == A_GET);
    endfunction

endpackage

// File: rtl/tl_ram_slave_if.sv
// TileLink-UL A/D channel bundle between a crossbar master port and a responder.
interface tilelink #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SRC_W  = 4
);
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W/8-1:0]   a_mask;
    logic [DATA_W-1:0]     a_data;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [2:0]            d_size;
    logic [SRC_W-1:0]      d_source;
    logic [DATA_W-1:0]     d_data;
    logic                  d_error;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
endinterface

// File: rtl/tl_ram_slave_resp_fifo.sv
// Two-entry response FIFO holding formed D beats until the D channel accepts them.
module tl_resp_fifo
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tl_d_beat_t push_beat,
    input  logic       pop,
    output tl_d_beat_t head,
    output logic [1:0] count
);
    tl_d_beat_t mem_q [2];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] count_q;
    logic       do_pop;

    assign do_pop = pop && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= push_beat;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(do_pop);
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/tl_ram_slave.sv
// TileLink-UL RAM responder: decodes A requests against a word RAM, answers on D in accept order.
module tl_ram_slave
    import tl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = TL_DATA_W,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned BASE   = 0,
    parameter int unsigned SRC_W  = TL_SRC_W
) (
    input logic  clk,
    input logic  rst,
    tilelink.slave tl
);
    localparam int unsigned BYTES      = DATA_W / 8;
    localparam int unsigned LANE_SHIFT = $clog2(BYTES);
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned RANGE      = DEPTH * BYTES;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] align_mask;
    logic              in_range;
    logic              size_ok;
    logic              aligned;
    logic              req_err;
    logic              is_get;
    logic              is_put;
    logic              accept;
    logic [IDX_W-1:0]  idx;

    logic              s1_valid_q;
    logic              s1_use_rd_q;
    logic              s1_err_q;
    logic [2:0]        s1_opcode_q;
    logic [2:0]        s1_size_q;
    logic [SRC_W-1:0]  s1_source_q;

    tl_d_beat_t        push_beat;
    tl_d_beat_t        head;
    logic [1:0]        fifo_count;
    logic              pop;

    always_comb begin
        offset     = tl.a_address - ADDR_W'(BASE);
        in_range   = (tl.a_address >= ADDR_W'(BASE)) && (offset < ADDR_W'(RANGE));
        size_ok    = 32'(tl.a_size) <= LANE_SHIFT;
        align_mask = (ADDR_W'(1) << tl.a_size) - ADDR_W'(1);
        aligned    = (tl.a_address & align_mask) == '0;
        is_get     = tl.a_opcode == A_GET;
        is_put     = (tl.a_opcode == A_PUT_FULL) || (tl.a_opcode == A_PUT_PARTIAL);
        req_err    = !(a_op_supported(tl.a_opcode) && size_ok && aligned && in_range);
        idx        = IDX_W'(offset >> LANE_SHIFT);
    end

    // Credit counts both the stage-1 slot and FIFO occupancy so a push never finds the FIFO full.
    assign tl.a_ready = !rst && ((fifo_count + 2'(s1_valid_q)) < 2'd2);
    assign accept     = tl.a_valid && tl.a_ready;

    always_ff @(posedge clk) begin
        if (accept && !req_err && is_put) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if ((tl.a_opcode == A_PUT_FULL) || tl.a_mask[i]) begin
                    mem_q[idx][i*8 +: 8] <= tl.a_data[i*8 +: 8];
                end
            end
        end
        if (accept && !req_err && is_get) begin
            rd_data_q <= mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_use_rd_q <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_opcode_q <= 3'd0;
            s1_size_q   <= 3'd0;
            s1_source_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_use_rd_q <= is_get && !req_err;
                s1_err_q    <= req_err;
                s1_opcode_q <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                s1_size_q   <= tl.a_size;
                s1_source_q <= tl.a_source;
            end
        end
    end

    always_comb begin
        push_beat        = '0;
        push_beat.opcode = s1_opcode_q;
        push_beat.size   = s1_size_q;
        push_beat.source = s1_source_q;
        push_beat.data   = s1_use_rd_q ? rd_data_q : '0;
        push_beat.error  = s1_err_q;
    end

    assign pop = tl.d_valid && tl.d_ready;

    tl_resp_fifo u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_q),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign tl.d_valid  = fifo_count != 2'd0;
    assign tl.d_opcode = head.opcode;
    assign tl.d_size   = head.size;
    assign tl.d_source = head.source;
    assign tl.d_data   = head.data;
    assign tl.d_error  = head.error;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Directed bench for tl_ram_slave with an in-order D-beat scoreboard.
module tb_tl_ram_slave;
    import tl_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SRC_W  = 4;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned BASE   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tilelink #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) tl ();

    tl_ram_slave #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .SRC_W  (SRC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tl  (tl)
    );

    tl_d_beat_t sb[$];
    int         tests_run = 0;
    int         fails     = 0;
    logic       stall_valid = 1'b0;
    tl_d_beat_t stall_beat;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tl_d_beat_t mk(input logic [2:0] op, input logic [2:0] size,
                                      input logic [3:0] src, input logic [63:0] data,
                                      input logic err);
        tl_d_beat_t b;
        b.opcode = op;
        b.size   = size;
        b.source = src;
        b.data   = data;
        b.error  = err;
        return b;
    endfunction

    function automatic tl_d_beat_t beat_now();
        return mk(tl.d_opcode, tl.d_size, tl.d_source, tl.d_data, tl.d_error);
    endfunction

    // D-channel monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_valid <= 1'b0;
        end else begin
            if (stall_valid) begin
                check("stall_stable", 128'({tl.d_valid, beat_now()}), 128'({1'b1, stall_beat}));
            end
            if (tl.d_valid && tl.d_ready) begin
                if (sb.size() == 0) begin
                    check("beat_expected", 128'(sb.size() != 0), 128'(1));
                end else begin
                    check("d_beat", 128'(beat_now()), 128'(sb.pop_front()));
                end
            end
            stall_valid <= tl.d_valid && !tl.d_ready;
            stall_beat  <= beat_now();
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                         input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
        tl.a_valid   = 1'b1;
        tl.a_opcode  = op;
        tl.a_size    = size;
        tl.a_source  = src;
        tl.a_address = addr;
        tl.a_mask    = mask;
        tl.a_data    = data;
    endtask

    // Holds the request until accepted; leaves a_valid high so calls can chain back-to-back.
    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                        input tl_d_beat_t exp);
        int waits = 0;
        drive(op, size, src, addr, mask, data);
        @(negedge clk);
        while (!tl.a_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        check("accept_in_budget", 128'(tl.a_ready), 128'(1));
        if (tl.a_ready) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tl.a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("drain", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        tl.d_ready = 1'b1;
        drive(3'(A_GET), 3'd3, 4'd0, 32'h0, 8'hFF, 64'h0);

        // Reset with a_valid held high: nothing may be accepted or answered.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_d_valid", 128'(tl.d_valid), 128'(0));
            check("reset_d_payload", 128'(beat_now()), 128'(0));
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("a_ready_after_reset", 128'(tl.a_ready), 128'(1));
        repeat (3) begin
            @(negedge clk);
            check("idle_d_valid", 128'(tl.d_valid), 128'(0));
        end
        @(posedge clk);
        #1;

        // PutFull then Get to the same word; Get answer lands two cycles after its accept.
        send(3'(A_PUT_FULL), 3'd3, 4'd5, 32'h8, 8'hFF, 64'hDEADBEEF_01234567,
             mk(3'(D_ACCESS_ACK), 3'd3, 4'd5, 64'h0, 1'b0));
        send(3'(A_GET), 3'd3, 4'd3, 32'h8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd3, 64'hDEADBEEF_01234567, 1'b0));
        idle();
        @(negedge clk);
        check("latency_head_put", 128'({tl.d_valid, tl.d_opcode, tl.d_source}),
              128'({1'b1, 3'd0, 4'd5}));
        @(negedge clk);
        check("latency_head_get", 128'({tl.d_valid, tl.d_opcode, tl.d_source}),
              128'({1'b1, 3'd1, 4'd3}));
        drain();

        // PutPartial on the low four lanes.
        send(3'(A_PUT_PARTIAL), 3'd3, 4'd7, 32'h8, 8'h0F, 64'hFFFFFFFF_AAAAAAAA,
             mk(3'(D_ACCESS_ACK), 3'd3, 4'd7, 64'h0, 1'b0));
        send(3'(A_GET), 3'd3, 4'd2, 32'h8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd2, 64'hDEADBEEF_AAAAAAAA, 1'b0));
        idle();
        drain();

        // Backpressure: two Gets fit, the third waits for the first D pop.
        tl.d_ready = 1'b0;
        send(3'(A_GET), 3'd3, 4'd1, 32'h8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd1, 64'hDEADBEEF_AAAAAAAA, 1'b0));
        send(3'(A_GET), 3'd3, 4'd2, 32'h8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd2, 64'hDEADBEEF_AAAAAAAA, 1'b0));
        drive(3'(A_GET), 3'd3, 4'd4, 32'h8, 8'hFF, 64'h0);
        repeat (3) begin
            @(negedge clk);
            check("credit_block", 128'(tl.a_ready), 128'(0));
        end
        check("stall_holds_two", 128'({tl.d_valid, tl.d_source}), 128'({1'b1, 4'd1}));
        @(posedge clk);
        #1;
        tl.d_ready = 1'b1;
        send(3'(A_GET), 3'd3, 4'd4, 32'h8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd4, 64'hDEADBEEF_AAAAAAAA, 1'b0));
        idle();
        drain();

        // Error responses: out of range, unsupported opcode, misaligned, oversize.
        send(3'(A_GET), 3'd3, 4'd6, DEPTH * 8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd6, 64'h0, 1'b1));
        send(3'd2, 3'd3, 4'd7, 32'h8, 8'hFF, 64'h11111111_11111111,
             mk(3'(D_ACCESS_ACK), 3'd3, 4'd7, 64'h0, 1'b1));
        send(3'(A_PUT_FULL), 3'd3, 4'd8, 32'hC, 8'hFF, 64'h22222222_22222222,
             mk(3'(D_ACCESS_ACK), 3'd3, 4'd8, 64'h0, 1'b1));
        send(3'(A_GET), 3'd4, 4'd9, 32'h0, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd4, 4'd9, 64'h0, 1'b1));
        send(3'(A_GET), 3'd3, 4'd10, 32'h8, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd10, 64'hDEADBEEF_AAAAAAAA, 1'b0));
        idle();
        drain();

        // Streamed puts and gets over a few distinct words.
        for (int i = 0; i < 4; i++) begin
            send(3'(A_PUT_FULL), 3'd3, 4'(i), 32'h100 + 32'(i * 8), 8'hFF,
                 {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)},
                 mk(3'(D_ACCESS_ACK), 3'd3, 4'(i), 64'h0, 1'b0));
        end
        for (int i = 0; i < 4; i++) begin
            send(3'(A_GET), 3'd3, 4'(i + 8), 32'h100 + 32'(i * 8), 8'hFF, 64'h0,
                 mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'(i + 8),
                    {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)}, 1'b0));
        end
        idle();
        drain();

        // Reset with two responses queued: they must vanish.
        tl.d_ready = 1'b0;
        send(3'(A_GET), 3'd3, 4'd1, 32'h100, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd1, 64'hC0DE0000_5A5A0000, 1'b0));
        send(3'(A_GET), 3'd3, 4'd2, 32'h108, 8'hFF, 64'h0,
             mk(3'(D_ACCESS_ACK_DATA), 3'd3, 4'd2, 64'hC0DE0001_5A5A0001, 1'b0));
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("queued_before_reset", 128'({tl.d_valid, tl.a_ready}), 128'({1'b1, 1'b0}));
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_drops_d_valid", 128'(tl.d_valid), 128'(0));
        check("reset_a_ready", 128'(tl.a_ready), 128'(1));
        tl.d_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_stale_beat", 128'(tl.d_valid), 128'(0));
        end

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
